// File: rtl/sbox_round_sched.sv
// DES S-box substitution sequencer: evaluates the eight S-boxes LANES at a time
// over STEPS = 8/LANES cycles and presents the assembled 32-bit pre-P word.
module sbox_round_sched #(
   parameter int LANES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [47:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        busy
);

   localparam int STEPS  = 8 / LANES;
   localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_lanes_check
      $error("sbox_round_sched: LANES must be 1, 2, 4 or 8");
   end

   // Row r of box b lives at index {b, r}; column c is the nibble at bits [4*(15-c) +: 4].
   localparam logic [63:0] SBOX_ROWS [32] = '{
      64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
      64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
      64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
      64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
      64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
      64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
      64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
      64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
   };

   function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] x);
      logic [63:0] row;
      row = SBOX_ROWS[{box, x[5], x[0]}];
      return row[{~x[4:1], 2'b00} +: 4];
   endfunction

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_next;
   logic [STEP_W-1:0] step, step_next;
   logic [47:0]       word_q;
   logic [31:0]       partial, partial_next;
   logic              load, finish;
   logic [5:0]        s_in  [8];
   logic [3:0]        s_out [8];

   // NOTE: every variable written in an always_comb gets a default first, so no
   // path through the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      step_next  = step;
      load       = 1'b0;
      finish     = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               load       = 1'b1;
               step_next  = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            if (step == STEP_LAST) begin
               finish     = 1'b1;
               step_next  = '0;
               state_next = DONE;
            end else begin
               step_next = step + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // clear overrides every transition, including an acceptance in IDLE.
      if (clear) begin
         state_next = IDLE;
         step_next  = '0;
         load       = 1'b0;
         finish     = 1'b0;
      end
   end

   // Only the boxes of the current step see their chunk; the rest are held at 0.
   always_comb begin
      partial_next = partial;
      for (int i = 0; i < 8; i++) begin
         s_in[i] = 6'd0;
         if (state == RUN && step == STEP_W'(i / LANES))
            s_in[i] = word_q[47-6*i -: 6];
         s_out[i] = sbox_lookup(3'(i), s_in[i]);
         if (state == RUN && step == STEP_W'(i / LANES))
            partial_next[31-4*i -: 4] = s_out[i];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         step     <= '0;
         word_q   <= '0;
         partial  <= '0;
         out_data <= '0;
      end else begin
         state <= state_next;
         step  <= step_next;
         if (load) begin
            word_q  <= in_data;
            partial <= '0;
         end else if (state == RUN) begin
            partial <= partial_next;
         end
         if (finish) out_data <= partial_next;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sbox_round_sched.sv
// Directed bench for sbox_round_sched: one instance per legal LANES value,
// expected results from hand-derived constants and an independent S-box table.
module tb_sbox_round_sched;

   logic        clk;
   logic        rst_n;
   logic        clear     [4];
   logic        in_valid  [4];
   logic        in_ready  [4];
   logic [47:0] in_data   [4];
   logic        out_valid [4];
   logic        out_ready [4];
   logic [31:0] out_data  [4];
   logic        busy      [4];

   int vectors    = 0;
   int miscompares = 0;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      sbox_round_sched #(.LANES(1 << g)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .clear     (clear[g]),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_data   (in_data[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_data  (out_data[g]),
         .busy      (busy[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Standard DES tables, one 64-bit word per row, column 0 in the top nibble.
   localparam logic [63:0] REF_ROWS [8][4] = '{
      '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
      '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
      '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
      '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
      '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
      '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
      '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
      '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
   };

   function automatic logic [3:0] ref_sbox(input logic [2:0] box, input logic [5:0] x);
      logic [1:0]  row;
      logic [3:0]  col;
      logic [63:0] w;
      row = {x[5], x[0]};
      col = x[4:1];
      w   = REF_ROWS[box][row];
      return w[(15 - int'(col)) * 4 +: 4];
   endfunction

   function automatic logic [31:0] ref_f(input logic [47:0] data);
      logic [31:0] r;
      r = '0;
      for (int j = 0; j < 8; j++)
         r[31-4*j -: 4] = ref_sbox(3'(j), data[47-6*j -: 6]);
      return r;
   endfunction

   task automatic send_word(input logic [1:0] k, input logic [47:0] data, input logic [31:0] exp,
                            input int exp_lat, input string name);
      int lat;
      @(negedge clk);
      vectors++;
      if (in_ready[k] !== 1'b1) begin
         miscompares++;
         $display("FAIL %s in_ready: got %b, expected 1", name, in_ready[k]);
      end
      in_valid[k]  = 1'b1;
      in_data[k]   = data;
      out_ready[k] = 1'b1;
      @(negedge clk);
      in_valid[k] = 1'b0;
      in_data[k]  = ~data;
      lat = 0;
      while (out_valid[k] !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      vectors++;
      if (lat != exp_lat) begin
         miscompares++;
         $display("FAIL %s latency: got %0d, expected %0d", name, lat, exp_lat);
      end
      vectors++;
      if (out_data[k] !== exp) begin
         miscompares++;
         $display("FAIL %s out_data: got %h, expected %h", name, out_data[k], exp);
      end
      @(negedge clk);
      vectors++;
      if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || out_data[k] !== exp) begin
         miscompares++;
         $display("FAIL %s after handshake: valid=%b ready=%b data=%h, expected 0 1 %h",
                  name, out_valid[k], in_ready[k], out_data[k], exp);
      end
   endtask

   task automatic check_reset_values(input logic [1:0] k, input string name);
      vectors++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0 || out_data[k] !== 32'h0) begin
         miscompares++;
         $display("FAIL %s lanes_idx=%0d: ready=%b valid=%b busy=%b data=%h, expected 1 0 0 00000000",
                  name, k, in_ready[k], out_valid[k], busy[k], out_data[k]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         clear[k]     = 1'b0;
         in_valid[k]  = 1'b0;
         in_data[k]   = '0;
         out_ready[k] = 1'b0;
      end
      #3;
      for (int k = 0; k < 4; k++) check_reset_values(2'(k), "reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) check_reset_values(2'(k), "after_reset_release");
   endtask

   task automatic test_basic();
      send_word(2'd0, 48'h0, 32'hEFA72C4D, 8, "zero_word_l1");
   endtask

   task automatic test_lanes();
      for (int k = 0; k < 4; k++)
         send_word(2'(k), 48'h6117BA866527, 32'h5C82B597, 8 >> k, "des_vector");
   endtask

   task automatic test_backpressure();
      int lat;
      int bad;
      @(negedge clk);
      out_ready[1] = 1'b0;
      in_valid[1]  = 1'b1;
      in_data[1]   = 48'h0;
      @(negedge clk);
      in_valid[1] = 1'b0;
      lat = 0;
      while (out_valid[1] !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      vectors++;
      if (lat != 4) begin
         miscompares++;
         $display("FAIL backpressure latency: got %0d, expected 4", lat);
      end
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         in_valid[1] = c[0];
         in_data[1]  = 48'h6117BA866527;
         @(negedge clk);
         vectors++;
         if (out_valid[1] !== 1'b1 || in_ready[1] !== 1'b0 || busy[1] !== 1'b1 || out_data[1] !== 32'hEFA72C4D) begin
            miscompares++;
            $display("FAIL backpressure hold cycle %0d: valid=%b ready=%b busy=%b data=%h, expected 1 0 1 efa72c4d",
                     c, out_valid[1], in_ready[1], busy[1], out_data[1]);
         end
      end
      in_valid[1]  = 1'b0;
      out_ready[1] = 1'b1;
      @(negedge clk);
      vectors++;
      if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1 || out_data[1] !== 32'hEFA72C4D) begin
         miscompares++;
         $display("FAIL backpressure release: valid=%b ready=%b data=%h, expected 0 1 efa72c4d",
                  out_valid[1], in_ready[1], out_data[1]);
      end
      send_word(2'd1, 48'h6117BA866527, 32'h5C82B597, 4, "after_backpressure");
   endtask

   task automatic test_clear();
      logic seen;
      @(negedge clk);
      clear[0]    = 1'b1;
      in_valid[0] = 1'b1;
      in_data[0]  = 48'h6117BA866527;
      @(negedge clk);
      clear[0]    = 1'b0;
      in_valid[0] = 1'b0;
      vectors++;
      if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_in_idle: ready=%b busy=%b, expected 1 0", in_ready[0], busy[0]);
      end
      in_valid[0] = 1'b1;
      in_data[0]  = 48'hFFFFFFFFFFFF;
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (busy[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_pre_run: busy=%b valid=%b, expected 1 0", busy[0], out_valid[0]);
      end
      clear[0] = 1'b1;
      @(negedge clk);
      clear[0] = 1'b0;
      vectors++;
      if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0 || out_valid[0] !== 1'b0 || out_data[0] !== 32'h5C82B597) begin
         miscompares++;
         $display("FAIL clear_mid_run: ready=%b busy=%b valid=%b data=%h, expected 1 0 0 5c82b597",
                  in_ready[0], busy[0], out_valid[0], out_data[0]);
      end
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid[0] !== 1'b0) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0 || out_data[0] !== 32'h5C82B597) begin
         miscompares++;
         $display("FAIL clear_no_output: valid_seen=%b data=%h, expected 0 5c82b597", seen, out_data[0]);
      end
      send_word(2'd0, 48'h0, 32'hEFA72C4D, 8, "clear_recover");
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      in_valid[0] = 1'b1;
      in_data[0]  = 48'h6117BA866527;
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (4) @(negedge clk);
      vectors++;
      if (busy[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL async_reset_pre: busy=%b, expected 1", busy[0]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) check_reset_values(2'(k), "async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check_reset_values(2'd0, "async_reset_no_output");
   endtask

   task automatic test_exhaustive();
      logic [47:0] data;
      for (int k = 0; k < 4; k += 3) begin
         for (int v = 0; v < 64; v++) begin
            for (int j = 0; j < 8; j++)
               data[47-6*j -: 6] = 6'((v + 11 * j) % 64);
            send_word(2'(k), data, ref_f(data), 8 >> k, "exhaustive");
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_lanes();
      test_backpressure();
      test_clear();
      test_async_reset();
      test_exhaustive();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
